// File: rtl/dac_replay_engine.sv
// dac_replay_engine
//   Holds a waveform loaded over AXI-Stream in an on-chip buffer and replays
//   it to an RFSoC DAC stream after a qualified trigger plus a programmable
//   delay, for a programmable number of passes (0 = until flushed).
//
//   Optional build macro: DAC_REPLAY_IDLE_ZERO_EN
//     defined   : outside PLAY the DAC stream carries valid zero samples.
//     undefined : outside PLAY the DAC stream is idle (tvalid 0, tdata 0).
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready/tlast  waveform load stream (sink)
//   m_axis_tdata/tvalid/tready   replay stream to the DAC (source)
//   load_start, arm, flush       single-cycle control pulses
//   trigger_in, select_in        trigger, qualified by channel select
//   cfg_repeat                   pass count latched at trigger (0 = endless)
//   cfg_delay                    trigger-to-play delay in cycles
//   wave_len                     number of beats held in the buffer
//   busy                         high in LOAD, DELAY and PLAY
//   done                         one-cycle pulse when the last pass ends
//   underrun                     sticky: DAC stalled during PLAY
module dac_replay_engine #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 10,
    parameter int REP_W  = 16,
    parameter int DLY_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic              load_start,
    input  logic              arm,
    input  logic              flush,
    input  logic              trigger_in,
    input  logic              select_in,
    input  logic [REP_W-1:0]  cfg_repeat,
    input  logic [DLY_W-1:0]  cfg_delay,
    output logic [ADDR_W:0]   wave_len,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(DEPTH - 1);
`ifdef DAC_REPLAY_IDLE_ZERO_EN
    localparam logic IDLE_VLD = 1'b1;
`else
    localparam logic IDLE_VLD = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, ARMED, DELAY, PLAY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   wlen_q, wlen_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic [REP_W-1:0]  pass_q, pass_d;
    logic              done_q, done_d;
    logic              und_q, und_d;
    logic              tvalid_q, tvalid_d;
    logic [DATA_W-1:0] tdata_q;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;
    logic              beat_acc;
    logic              last_beat;

    logic [DATA_W-1:0] mem [DEPTH];

    assign beat_acc  = tvalid_q && m_axis_tready;
    // addr_q is the address of the beat currently presented on the output
    assign last_beat = ({1'b0, addr_q} == (wlen_q - (ADDR_W+1)'(1)));

    always_comb begin
        state_d = state_q;
        wlen_d  = wlen_q;
        dly_d   = dly_q;
        addr_d  = addr_q;
        rep_d   = rep_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        und_d   = und_q;
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    wlen_d  = '0;
                    und_d   = 1'b0;
                end else if (arm && (wlen_q != '0)) begin
                    state_d = ARMED;
                end
            end
            LOAD: begin
                if (s_axis_tvalid) begin
                    wr_en  = 1'b1;
                    wlen_d = wlen_q + (ADDR_W+1)'(1);
                    if (s_axis_tlast || (wlen_q == LAST_SLOT)) state_d = IDLE;
                end
            end
            ARMED: begin
                if (trigger_in && select_in) begin
                    state_d = DELAY;
                    dly_d   = cfg_delay;
                    rep_d   = cfg_repeat;
                    pass_d  = cfg_repeat;
                end
            end
            DELAY: begin
                if (dly_q == '0) begin
                    // Fetch beat 0 on the way into PLAY so it is presented
                    // on the first PLAY cycle.
                    state_d = PLAY;
                    addr_d  = '0;
                    rd_en   = 1'b1;
                    rd_addr = '0;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            PLAY: begin
                if (!m_axis_tready) und_d = 1'b1;
                if (beat_acc) begin
                    if (last_beat) begin
                        if ((rep_q != '0) && (pass_q == REP_W'(1))) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            // Wrap straight to beat 0 so the stream has no bubble
                            addr_d  = '0;
                            rd_en   = 1'b1;
                            rd_addr = '0;
                            if (rep_q != '0) pass_d = pass_q - REP_W'(1);
                        end
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        rd_en   = 1'b1;
                        rd_addr = addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // flush overrides every other event in the same cycle
        if (flush) begin
            state_d = IDLE;
            wlen_d  = wlen_q;
            dly_d   = '0;
            addr_d  = '0;
            rep_d   = '0;
            pass_d  = '0;
            done_d  = 1'b0;
            rd_en   = 1'b0;
            wr_en   = 1'b0;
            und_d   = und_q | ((state_q == PLAY) && !m_axis_tready);
        end

        tvalid_d = (state_d == PLAY) ? 1'b1 : IDLE_VLD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wlen_q   <= '0;
            dly_q    <= '0;
            addr_q   <= '0;
            rep_q    <= '0;
            pass_q   <= '0;
            done_q   <= 1'b0;
            und_q    <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wlen_q   <= wlen_d;
            dly_q    <= dly_d;
            addr_q   <= addr_d;
            rep_q    <= rep_d;
            pass_q   <= pass_d;
            done_q   <= done_d;
            und_q    <= und_d;
            tvalid_q <= tvalid_d;
            // Output register doubles as the buffer read register; it only
            // moves on a fetch, which keeps the beat stable under backpressure.
            if (rd_en) begin
                tdata_q <= mem[rd_addr];
            end else if (state_d != PLAY) begin
                tdata_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wlen_q[ADDR_W-1:0]] <= s_axis_tdata;
    end

    assign s_axis_tready = (state_q == LOAD);
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign wave_len      = wlen_q;
    assign busy          = (state_q == LOAD) || (state_q == DELAY) || (state_q == PLAY);
    assign done          = done_q;
    assign underrun      = und_q;

endmodule

// File: tb/tb_dac_replay_engine.sv
// Directed bench for dac_replay_engine with a small buffer (8 beats).
module tb_dac_replay_engine;

    localparam int DW = 32;
    localparam int AW = 3;
`ifdef DAC_REPLAY_IDLE_ZERO_EN
    localparam logic IDLE_VLD = 1'b1;
`else
    localparam logic IDLE_VLD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          load_start = 1'b0;
    logic          arm = 1'b0;
    logic          flush = 1'b0;
    logic          trigger_in = 1'b0;
    logic          select_in = 1'b0;
    logic [7:0]    cfg_repeat = '0;
    logic [7:0]    cfg_delay = '0;
    logic [AW:0]   wave_len;
    logic          busy;
    logic          done;
    logic          underrun;

    int n_cmp = 0;
    int n_fail = 0;

    dac_replay_engine #(.DATA_W(DW), .ADDR_W(AW), .REP_W(8), .DLY_W(8)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .load_start(load_start), .arm(arm), .flush(flush),
        .trigger_in(trigger_in), .select_in(select_in),
        .cfg_repeat(cfg_repeat), .cfg_delay(cfg_delay),
        .wave_len(wave_len), .busy(busy), .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_beats(input int n, input int last_idx, input logic [DW-1:0] base, output int acc);
        load_start = 1'b1; tick(); load_start = 1'b0;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            s_tdata  = base + DW'(i);
            s_tvalid = 1'b1;
            s_tlast  = (i == last_idx);
            if (s_tready) acc++;
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick();
        n_cmp++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
        n_cmp++; if (m_tdata !== '0) begin n_fail++; $display("FAIL rst_tdata: got %h want 0", m_tdata); end
        n_cmp++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b want 0", s_tready); end
        n_cmp++; if ({busy, done, underrun} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {busy, done, underrun}); end
        n_cmp++; if (wave_len !== '0) begin n_fail++; $display("FAIL rst_wlen: got %0d want 0", wave_len); end
        rst = 1'b0; tick();
        n_cmp++; if (m_tvalid !== IDLE_VLD) begin n_fail++; $display("FAIL idle_tvalid: got %b want %b", m_tvalid, IDLE_VLD); end
    endtask

    task automatic test_basic_play();
        int acc;
        logic [DW-1:0] base = 32'hA000_0000;
        load_beats(6, 3, base, acc);
        n_cmp++; if (acc != 4) begin n_fail++; $display("FAIL load_acc: got %0d want 4", acc); end
        n_cmp++; if (wave_len !== 4'd4) begin n_fail++; $display("FAIL load_wlen: got %0d want 4", wave_len); end
        n_cmp++; if ({s_tready, busy} !== 2'b00) begin n_fail++; $display("FAIL load_exit: got %b want 00", {s_tready, busy}); end
        arm = 1'b1; tick(); arm = 1'b0;
        cfg_delay = 8'd3; cfg_repeat = 8'd2; m_tready = 1'b1;
        trigger_in = 1'b1; select_in = 1'b1; tick();
        trigger_in = 1'b0; select_in = 1'b0; cfg_repeat = 8'd0;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL delay_busy: got %b want 1", busy); end
        tick(); tick(); tick();
        n_cmp++; if (m_tvalid !== IDLE_VLD || m_tdata !== '0) begin n_fail++; $display("FAIL pre_play: got %b/%h want %b/0", m_tvalid, m_tdata, IDLE_VLD); end
        tick();
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== base + DW'(k % 4)) begin n_fail++; $display("FAIL play_beat%0d: got %b/%h want 1/%h", k, m_tvalid, m_tdata, base + DW'(k % 4)); end
            n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL early_done%0d: got %b want 0", k, done); end
        end
        tick();
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got done=%b busy=%b want 1/0", done, busy); end
        n_cmp++; if (m_tvalid !== IDLE_VLD || m_tdata !== '0) begin n_fail++; $display("FAIL post_play: got %b/%h want %b/0", m_tvalid, m_tdata, IDLE_VLD); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b want 0", done); end
        n_cmp++; if (wave_len !== 4'd4) begin n_fail++; $display("FAIL wlen_kept: got %0d want 4", wave_len); end
    endtask

    task automatic test_stall_flush();
        logic [DW-1:0] base = 32'hA000_0000;
        int seq_a[3] = '{0, 1, 2};
        int seq_b[3] = '{3, 0, 1};
        arm = 1'b1; tick(); arm = 1'b0;
        cfg_delay = 8'd0; cfg_repeat = 8'd0; m_tready = 1'b1;
        trigger_in = 1'b1; select_in = 1'b1; tick();
        trigger_in = 1'b0; select_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (m_tdata !== base + DW'(seq_a[k])) begin n_fail++; $display("FAIL stall_pre%0d: got %h want %h", k, m_tdata, base + DW'(seq_a[k])); end
        end
        n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL und_early: got %b want 0", underrun); end
        m_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== base + 32'd2) begin n_fail++; $display("FAIL stall_hold%0d: got %b/%h want 1/%h", k, m_tvalid, m_tdata, base + 32'd2); end
        end
        n_cmp++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL und_set: got %b want 1", underrun); end
        m_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (m_tdata !== base + DW'(seq_b[k])) begin n_fail++; $display("FAIL stall_post%0d: got %h want %h", k, m_tdata, base + DW'(seq_b[k])); end
        end
        flush = 1'b1; tick(); flush = 1'b0;
        n_cmp++; if (busy !== 1'b0 || m_tvalid !== IDLE_VLD || m_tdata !== '0) begin n_fail++; $display("FAIL flush_idle: got busy=%b %b/%h want 0 %b/0", busy, m_tvalid, m_tdata, IDLE_VLD); end
        n_cmp++; if (underrun !== 1'b1 || wave_len !== 4'd4) begin n_fail++; $display("FAIL flush_keep: got und=%b wlen=%0d want 1/4", underrun, wave_len); end
    endtask

    task automatic test_ignored();
        trigger_in = 1'b1; select_in = 1'b1; tick(); tick();
        trigger_in = 1'b0; select_in = 1'b0; tick();
        n_cmp++; if (busy !== 1'b0 || m_tvalid !== IDLE_VLD) begin n_fail++; $display("FAIL idle_trig: got busy=%b vld=%b want 0/%b", busy, m_tvalid, IDLE_VLD); end
        arm = 1'b1; tick(); arm = 1'b0;
        trigger_in = 1'b1; select_in = 1'b0; tick(); tick();
        trigger_in = 1'b0; select_in = 1'b1; tick(); select_in = 1'b0; tick();
        n_cmp++; if (busy !== 1'b0 || m_tvalid !== IDLE_VLD) begin n_fail++; $display("FAIL unsel_trig: got busy=%b vld=%b want 0/%b", busy, m_tvalid, IDLE_VLD); end
        flush = 1'b1; tick(); flush = 1'b0;
        load_start = 1'b1; tick(); load_start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || s_tready !== 1'b1 || wave_len !== '0) begin n_fail++; $display("FAIL load_enter: got busy=%b rdy=%b wlen=%0d want 1/1/0", busy, s_tready, wave_len); end
        n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL und_clear: got %b want 0", underrun); end
        flush = 1'b1; tick(); flush = 1'b0;
        n_cmp++; if (busy !== 1'b0 || s_tready !== 1'b0 || wave_len !== '0) begin n_fail++; $display("FAIL load_flush: got busy=%b rdy=%b wlen=%0d want 0/0/0", busy, s_tready, wave_len); end
        arm = 1'b1; tick(); arm = 1'b0;
        trigger_in = 1'b1; select_in = 1'b1; tick();
        trigger_in = 1'b0; select_in = 1'b0; tick(); tick();
        n_cmp++; if (busy !== 1'b0 || m_tvalid !== IDLE_VLD) begin n_fail++; $display("FAIL arm_empty: got busy=%b vld=%b want 0/%b", busy, m_tvalid, IDLE_VLD); end
    endtask

    task automatic test_overflow();
        int acc;
        logic [DW-1:0] base = 32'hC000_0000;
        load_beats(10, 99, base, acc);
        n_cmp++; if (acc != 8) begin n_fail++; $display("FAIL ovf_acc: got %0d want 8", acc); end
        n_cmp++; if (wave_len !== 4'd8 || s_tready !== 1'b0) begin n_fail++; $display("FAIL ovf_wlen: got wlen=%0d rdy=%b want 8/0", wave_len, s_tready); end
        arm = 1'b1; tick(); arm = 1'b0;
        cfg_delay = 8'd1; cfg_repeat = 8'd1; m_tready = 1'b1;
        trigger_in = 1'b1; select_in = 1'b1; tick();
        trigger_in = 1'b0; select_in = 1'b0; tick();
        n_cmp++; if (m_tvalid !== IDLE_VLD || m_tdata !== '0) begin n_fail++; $display("FAIL ovf_prelay: got %b/%h want %b/0", m_tvalid, m_tdata, IDLE_VLD); end
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== base + DW'(k)) begin n_fail++; $display("FAIL ovf_beat%0d: got %b/%h want 1/%h", k, m_tvalid, m_tdata, base + DW'(k)); end
        end
        tick();
        n_cmp++; if (done !== 1'b1 || m_tvalid !== IDLE_VLD) begin n_fail++; $display("FAIL ovf_done: got done=%b vld=%b want 1/%b", done, m_tvalid, IDLE_VLD); end
    endtask

    task automatic test_reset_play();
        logic [DW-1:0] base = 32'hC000_0000;
        arm = 1'b1; tick(); arm = 1'b0;
        cfg_delay = 8'd0; cfg_repeat = 8'd0; m_tready = 1'b1;
        trigger_in = 1'b1; select_in = 1'b1; tick();
        trigger_in = 1'b0; select_in = 1'b0; tick();
        n_cmp++; if (m_tdata !== base) begin n_fail++; $display("FAIL rp_first: got %h want %h", m_tdata, base); end
        m_tready = 1'b0; tick(); m_tready = 1'b1;
        n_cmp++; if (underrun !== 1'b1 || m_tdata !== base) begin n_fail++; $display("FAIL rp_stall: got und=%b %h want 1/%h", underrun, m_tdata, base); end
        tick();
        n_cmp++; if (m_tdata !== base + 32'd1) begin n_fail++; $display("FAIL rp_second: got %h want %h", m_tdata, base + 32'd1); end
        rst = 1'b1; load_start = 1'b1; tick();
        n_cmp++; if (m_tvalid !== 1'b0 || m_tdata !== '0) begin n_fail++; $display("FAIL rp_out: got %b/%h want 0/0", m_tvalid, m_tdata); end
        n_cmp++; if ({busy, done, underrun, s_tready} !== 4'b0000 || wave_len !== '0) begin n_fail++; $display("FAIL rp_ctl: got %b wlen=%0d want 0000/0", {busy, done, underrun, s_tready}, wave_len); end
        rst = 1'b0; load_start = 1'b0; tick();
        n_cmp++; if (m_tvalid !== IDLE_VLD || m_tdata !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL rp_release: got %b/%h busy=%b want %b/0/0", m_tvalid, m_tdata, busy, IDLE_VLD); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_play();
        test_stall_flush();
        test_ignored();
        test_overflow();
        test_reset_play();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
